// File: rtl/alt_count_if.sv
// alt_count_if: sample strobe/count in, direction/lock/turn/period/error status out.
interface alt_count_if #(parameter int WIDTH = 4);
    logic             en;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             locked;
    logic             turn;
    logic [7:0]       cycles;
    logic             err;
    logic             err_sticky;
    modport master (output en, count, input dir, locked, turn, cycles, err, err_sticky);
    modport slave  (input en, count, output dir, locked, turn, cycles, err, err_sticky);
endinterface

// File: rtl/alt_count_checker.sv
// alt_count_checker: locks onto an up/down alternating count stream, flags illegal steps,
// pulses on turnarounds and counts completed LO->HI->LO periods.
module alt_count_checker #(
    parameter int WIDTH = 4,
    parameter int LO    = 0,
    parameter int HI    = 15
) (
    input logic         Clk,
    input logic         reset,
    alt_count_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SYNC, UP, DOWN} state_t;
    localparam logic [WIDTH:0] LO_V = (WIDTH+1)'(LO);
    localparam logic [WIDTH:0] HI_V = (WIDTH+1)'(HI);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             dir_q, dir_d, locked_q, locked_d, turn_q, turn_d;
    logic             err_q, err_d, sticky_q, sticky_d;
    logic [7:0]       cycles_q, cycles_d;
    logic [WIDTH:0]   p, s;
    logic             step_up, step_dn;
    // Widened by one bit so p+1 / p-1 never wrap inside a comparison.
    assign p       = {1'b0, prev_q};
    assign s       = {1'b0, bus.count};
    assign step_up = (p < HI_V) && (s == p + 1'b1);
    assign step_dn = (p > LO_V) && (s == p - 1'b1);
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        dir_d    = dir_q;
        turn_d   = 1'b0;
        err_d    = 1'b0;
        cycles_d = cycles_q;
        if (bus.en) begin
            prev_d = bus.count;
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    if (step_up) begin
                        state_d = UP;
                        dir_d   = 1'b1;
                    end else if (step_dn) begin
                        state_d = DOWN;
                        dir_d   = 1'b0;
                    end else err_d = 1'b1;
                end
                UP: begin
                    if (p == HI_V && s == HI_V - 1'b1) begin
                        turn_d  = 1'b1;
                        state_d = DOWN;
                        dir_d   = 1'b0;
                    end else if (!step_up) begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end
                end
                default: begin
                    if (p == LO_V && s == LO_V + 1'b1) begin
                        turn_d   = 1'b1;
                        cycles_d = cycles_q + 8'd1;
                        state_d  = UP;
                        dir_d    = 1'b1;
                    end else if (!step_dn) begin
                        err_d   = 1'b1;
                        state_d = SYNC;
                    end
                end
            endcase
        end
        locked_d = (state_d == UP) || (state_d == DOWN);
        sticky_d = sticky_q | err_d;
    end
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            turn_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cycles_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            turn_q   <= turn_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cycles_q <= cycles_d;
        end
    end
    assign bus.dir        = dir_q;
    assign bus.locked     = locked_q;
    assign bus.turn       = turn_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.cycles     = cycles_q;
endmodule

// File: tb/tb_alt_count_checker.sv
// tb_alt_count_checker: scoreboard bench with a trend-based reference model of the checker.
module tb_alt_count_checker;
    localparam int W = 4, LO = 0, HI = 15;
    typedef struct packed {
        logic       dir;
        logic       locked;
        logic       turn;
        logic [7:0] cycles;
        logic       err;
        logic       sticky;
    } obs_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alt_count_if #(.WIDTH(W)) bus ();
    alt_count_checker #(.WIDTH(W), .LO(LO), .HI(HI)) dut (.Clk(clk), .reset(rst_n), .bus(bus));
    obs_t exp_q[$];
    int   total = 0, bad = 0;
    // Reference model: trend is +1/-1 once locked, 0 while unlocked.
    bit   seen, mdir, msticky;
    int   trend, mprev, mcyc;
    function automatic obs_t observe();
        return {bus.dir, bus.locked, bus.turn, bus.cycles, bus.err, bus.err_sticky};
    endfunction
    function automatic void model_reset();
        seen = 0; mdir = 0; msticky = 0; trend = 0; mprev = 0; mcyc = 0;
    endfunction
    function automatic void model_step(bit e, int s);
        obs_t o;
        bit t = 0, er = 0;
        if (e) begin
            if (!seen) seen = 1;
            else if (trend == 0) begin
                if (mprev < HI && s == mprev + 1) begin trend = 1; mdir = 1; end
                else if (mprev > LO && s == mprev - 1) begin trend = -1; mdir = 0; end
                else er = 1;
            end else if (mprev == (trend > 0 ? HI : LO)) begin
                if (s == mprev - trend) begin
                    t = 1;
                    if (trend < 0) mcyc = (mcyc + 1) % 256;
                    trend = -trend;
                    mdir = (trend > 0);
                end else begin er = 1; trend = 0; end
            end else if (s != mprev + trend) begin
                er = 1; trend = 0;
            end
            mprev = s;
            msticky |= er;
        end
        o.dir = mdir; o.locked = (trend != 0); o.turn = t;
        o.cycles = 8'(mcyc); o.err = er; o.sticky = msticky;
        exp_q.push_back(o);
    endfunction
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = observe();
            total++;
            if (a !== e)
                begin
                    bad++;
                    $display("FAIL step t=%0t: got dir=%b lk=%b turn=%b cyc=%0d err=%b stk=%b, want dir=%b lk=%b turn=%b cyc=%0d err=%b stk=%b",
                             $time, a.dir, a.locked, a.turn, a.cycles, a.err, a.sticky,
                             e.dir, e.locked, e.turn, e.cycles, e.err, e.sticky);
                end
        end
    end
    task automatic drive(bit e, int c);
        @(negedge clk);
        bus.en = e;
        bus.count = W'(c);
        model_step(e, c);
    endtask
    task automatic seq(int a, int b);
        if (a <= b) for (int i = a; i <= b; i++) drive(1, i);
        else for (int i = a; i >= b; i--) drive(1, i);
    endtask
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (observe() !== '0) begin
            bad++;
            $display("FAIL async_reset: got %b, want all zero", observe());
        end
        model_reset();
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    function automatic int legal_next();
        if (trend > 0) return mprev == HI ? HI - 1 : mprev + 1;
        if (trend < 0) return mprev == LO ? LO + 1 : mprev - 1;
        return mprev < HI ? mprev + 1 : mprev - 1;
    endfunction
    initial begin
        int guard;
        model_reset();
        bus.en = 1'b0;
        bus.count = '0;
        repeat (2) @(negedge clk);
        total++;
        if (observe() !== '0) begin
            bad++;
            $display("FAIL reset_state: got %b, want all zero", observe());
        end
        rst_n = 1'b1;
        seq(0, 15); seq(14, 0); drive(1, 1);
        mid_reset();
        seq(9, 0); drive(1, 1);
        seq(2, 4); drive(1, 6); drive(1, 7);
        seq(8, 15); drive(1, 0); drive(1, 1);
        repeat (5) drive(0, $urandom_range(0, 15));
        seq(2, 3);
        while (mcyc < 5) begin seq(4, 15); seq(14, 0); seq(1, 3); end
        mid_reset();
        seq(2, 3);
        for (int k = 0; k < 2000; k++) begin
            int r = $urandom_range(0, 99);
            drive(r < 90, r < 80 ? legal_next() : int'($urandom_range(0, 15)));
        end
        mid_reset();
        drive(1, 0);
        repeat (256) begin seq(1, 15); seq(14, 0); end
        drive(1, 1);
        drive(0, 0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        #2;
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alt_count_checker.md
# alt_count_checker

Receive-side checker for the up/down alternating counter stream. It samples a WIDTH-bit count bus and locks onto its direction. It reports each turnaround and counts completed up/down periods. Any step that is not a legal ±1 move or a legal turnaround is flagged. It sits on the consumer side of the counter in the microwave controller, for timer sanity-checking and display sequencing.

## Interface
- WIDTH, 4, count bus width
- LO, 0, lower turnaround value; must satisfy LO < HI
- HI, 15, upper turnaround value; HI - LO >= 2 and HI <= 2**WIDTH-1
- Clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- en  in  1  sample strobe; count is consumed only on a rising Clk edge where en=1
- count  in  WIDTH  count value from the alternating counter
- dir  out  1  current tracked direction: 1 = up, 0 = down; valid only while locked=1
- locked  out  1  1 while the FSM is in UP or DOWN
- turn  out  1  one-cycle pulse on a legal turnaround
- cycles  out  8  completed periods (LO→HI→LO); modulo-256 counter
- err  out  1  one-cycle pulse on an illegal step
- err_sticky  out  1  set by any err; cleared only by reset

## Operation
- Registers:
  - prev (WIDTH bits): last sampled value.
  - FSM state: IDLE, SYNC, UP, DOWN.
- On every en=1 edge, prev <= count, regardless of outcome. All decisions compare count (s) against prev (p).
- Edges with en=0 change nothing and emit no pulses.
- IDLE: capture s, then go to SYNC. No outputs change.
- SYNC: decides direction from the first step.
  - s == p+1 with p < HI: go to UP, dir=1.
  - s == p-1 with p > LO: go to DOWN, dir=0.
  - Anything else, including s == p: err pulse, stay in SYNC.
- UP: expects a step up, or a turnaround at the top.
  - p < HI and s == p+1: stay in UP.
  - p == HI and s == HI-1: turn pulse, go to DOWN, dir=0.
  - Otherwise: err pulse, go to SYNC. This includes wrap-around (HI→LO), repeats, skips and out-of-range values.
- DOWN: expects a step down, or a turnaround at the bottom.
  - p > LO and s == p-1: stay in DOWN.
  - p == LO and s == LO+1: turn pulse, cycles += 1, go to UP, dir=1.
  - Otherwise: err pulse, go to SYNC.
- Arithmetic:
  - p+1 is evaluated only when p < HI, and p-1 only when p > LO, so there is no modular wrap in comparisons.
  - cycles wraps 255→0 silently.
- A period is counted only at the bottom turnaround, and only if the FSM was in DOWN. A stream first seen mid-descent still counts at its first LO turn.
- Values outside [LO, HI] are never legal. In SYNC they produce err and remain the new prev.
- dir keeps its last value while in IDLE or SYNC. Consumers must qualify dir with locked.

## Timing
- Reset values: state=IDLE, prev=0, dir=0, locked=0, turn=0, cycles=0, err=0, err_sticky=0.
- Reset asserts asynchronously. Deassertion is taken synchronously on the next Clk edge.
- Reset mid-operation abandons the current lock. The first en sample after reset is treated as a fresh capture (IDLE).
- All outputs are registered.
  - turn, err, dir, locked and cycles update on the same edge that consumes the triggering sample.
  - They are visible for exactly the following cycle (pulses); the other outputs hold until next changed.
- Lock latency: locked=1 after the second valid en sample. There is no latency beyond that edge.
- turn and err are mutually exclusive in any cycle.
- err_sticky rises on the same edge as the first err.
- Back-to-back en=1 every cycle is fully supported with no throughput loss.

## Test plan
- Clean stream, en=1 every cycle, count 0,1,…,15,14,…,0,1. Required:
  - locked=1 after sample 1.
  - turn pulses after 15→14 and after 0→1.
  - cycles=1, err_sticky=0.
- Mid-stream start at 9,8,7. Required:
  - DOWN entered after 8, locked=1, dir=0.
  - No err.
  - Continuing to 0,1 gives cycles=1.
- Skip 3,4,6,7. Required:
  - err pulse after 6, locked=0, err_sticky=1.
  - Relock UP after 7, dir=1.
- Wrap instead of turn: …,14,15,0. Required:
  - err after 0, no turn, FSM in SYNC.
  - Then 1 relocks UP.
- Stall handling: en=0 while count toggles randomly for 5 cycles, then resume the legal sequence. Required:
  - No err, no turn.
  - prev unchanged across the stall.
- Reset mid-run with cycles=5 and locked=1: pull reset low at an arbitrary non-edge time. Required:
  - All outputs 0 immediately, before the next Clk edge.
  - Next two samples 2,3 give locked=1, dir=1.
- cycles wrap: 256 full periods. Required: cycles returns to 0 with no err.
